// File: rtl/regfile_dump_ctrl_if.sv
// Register-dump stream: one beat per architectural register, valid/ready handshake.
interface regfile_dump_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dump_valid,
    output dump_addr,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_addr,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Run-then-inspect sequencer: lets the CPU run for a programmed number of cycles,
// freezes it, then steals regfile read port A and streams every register out.
module regfile_dump_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CYC_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  run_cycles,
  input  logic [ADDR_W-1:0] cpu_rs1,
  output logic [ADDR_W-1:0] rs1_out,
  input  logic [DATA_W-1:0] regA_in,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  regfile_dump_ctrl_if.master dump
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {StIdle, StRun, StScan, StHold, StDone} state_e;

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [CYC_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  // State register; reset drops back to idle with no partial beat kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Next-state: run countdown, then one settle cycle + one hold phase per register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          len_d   = run_cycles;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (run_cycles != '0) ? StRun : StScan;
        end
      end
      StRun: begin
        // Final increment lands on len_q, which always fits: no wrap.
        cnt_d = cnt_q + CYC_W'(1);
        if (cnt_q == len_q - CYC_W'(1)) begin
          state_d = StScan;
        end
      end
      StScan: begin
        // rs1_out has been idx for this whole cycle, so regA_in is settled.
        addr_d  = idx_q;
        data_d  = regA_in;
        last_d  = (idx_q == LastIdx);
        state_d = StHold;
      end
      StHold: begin
        if (dump.dump_ready) begin
          last_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = StScan;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state so reset clears them without waiting for a clock.
  always_comb begin
    cpu_run = (state_q == StRun);
    busy    = (state_q == StRun) || (state_q == StScan) || (state_q == StHold);
    done    = (state_q == StDone);
    rs1_out = ((state_q == StScan) || (state_q == StHold)) ? idx_q : cpu_rs1;
  end

  assign dump.dump_valid = (state_q == StHold);
  assign dump.dump_addr  = addr_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_last  = last_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench: driver queues expected beats at each start, monitor pops on handshake.
module tb_regfile_dump_ctrl;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int CYC_W    = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [CYC_W-1:0]  run_cycles;
  logic [ADDR_W-1:0] cpu_rs1;
  logic [ADDR_W-1:0] rs1_out;
  logic [DATA_W-1:0] regA_in;
  logic              cpu_run;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] regs [NUM_REGS];

  regfile_dump_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dump_if ();

  regfile_dump_ctrl #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .run_cycles (run_cycles),
    .cpu_rs1    (cpu_rs1),
    .rs1_out    (rs1_out),
    .regA_in    (regA_in),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .done       (done),
    .dump       (dump_if)
  );

  // Combinational regfile read port A.
  assign regA_in = regs[rs1_out];

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    run_cnt = 0;
  int    beat_cnt = 0;
  int    stall_addr = -1;
  int    stall_len = 0;
  int    stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Consumer: stalls a chosen beat for stall_len cycles, otherwise always ready.
  initial begin
    dump_if.dump_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (dump_if.dump_valid && int'(dump_if.dump_addr) == stall_addr && stall_cnt < stall_len)
      begin
        dump_if.dump_ready = 1'b0;
        stall_cnt++;
      end else begin
        dump_if.dump_ready = 1'b1;
      end
    end
  end

  // Monitor: counts run cycles, checks steering, stability under stall, and beats.
  logic  stalled;
  beat_t held;
  beat_t got;
  initial begin
    stalled = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (cpu_run) begin
          run_cnt++;
          check("rs1_during_run", rs1_out, cpu_rs1);
        end
        if (stalled) begin
          check("stall_valid", dump_if.dump_valid, 1);
          check("stall_addr", dump_if.dump_addr, held.addr);
          check("stall_data", dump_if.dump_data, held.data);
        end
        if (dump_if.dump_valid) begin
          check("rs1_during_hold", rs1_out, dump_if.dump_addr);
        end
        if (dump_if.dump_valid && dump_if.dump_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL extra_beat: got addr %0d expected no beat", dump_if.dump_addr);
          end else begin
            got = exp_q.pop_front();
            check("beat_addr", dump_if.dump_addr, got.addr);
            check("beat_data", dump_if.dump_data, got.data);
            check("beat_last", dump_if.dump_last, got.last);
            if (got.last) check("done_before_final_hs", done, 0);
            beat_cnt++;
          end
          stalled = 1'b0;
        end else if (dump_if.dump_valid) begin
          stalled = 1'b1;
          held = '{addr: dump_if.dump_addr, data: dump_if.dump_data, last: dump_if.dump_last};
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic push_expected();
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: regs[i], last: (i == NUM_REGS - 1)});
    end
  endtask

  task automatic run_session(input int len, input bit mid_start);
    int t;
    run_cnt   = 0;
    beat_cnt  = 0;
    stall_cnt = 0;
    push_expected();
    run_cycles = CYC_W'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_cpu_run", cpu_run, (len != 0));
    if (len == 0) check("zero_run_scan_rs1", rs1_out, 0);
    if (mid_start) begin
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    t = 0;
    while (!done && t < 3000) begin
      tick();
      t++;
    end
    check("session_done", done, 1);
    check("session_busy_low", busy, 0);
    check("run_cycles_count", run_cnt, len);
    check("beat_count", beat_cnt, NUM_REGS);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hA500_0000 | (i * 32'h0001_0101);
    regs[0] = 32'h0;
    regs[5] = 32'hDEAD_BEEF;
    cpu_rs1    = 5'd3;
    start      = 1'b0;
    run_cycles = '0;
    reset      = 1'b1;
    #1;
    check("rst_valid", dump_if.dump_valid, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", dump_if.dump_addr, 0);
    check("rst_data", dump_if.dump_data, 0);
    check("rst_last", dump_if.dump_last, 0);
    check("rst_rs1_passthru", rs1_out, 3);
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_session(10, 1'b0);
    run_session(0, 1'b0);
    stall_addr = 5;
    stall_len  = 7;
    run_session(4, 1'b0);
    stall_addr = -1;
    run_session(20, 1'b1);

    // Asynchronous reset in the middle of beat 12's hold phase.
    push_expected();
    run_cycles = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!(dump_if.dump_valid && dump_if.dump_addr == 5'd12) && t < 500) begin
      @(negedge clock);
      t++;
    end
    check("reach_beat12", dump_if.dump_addr, 12);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_valid", dump_if.dump_valid, 0);
    check("async_rst_cpu_run", cpu_run, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_valid", dump_if.dump_valid, 0);
    check("post_rst_rs1", rs1_out, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
